// File: rtl/jtcontra_obj_dma_pkg.sv
// rtl/jtcontra_obj_dma_pkg.sv - shared types and sizes for the object DMA
package jtcontra_obj_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COPY  = 2'd1,
    FLUSH = 2'd2
  } dma_state_e;

  localparam int OBJ_SIZE     = 5;
  localparam int OBJ_MAX      = 64;
  localparam int COPY_LEN_DEF = OBJ_SIZE * OBJ_MAX;

endpackage

// File: rtl/jtframe_dual_ram.sv
// rtl/jtframe_dual_ram.sv - simple dual-port byte RAM, port A read/write, port B read
// Both read ports are registered; a same-cycle write on A and read on B returns the old byte.
module jtframe_dual_ram #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] a_addr,
  input  logic          a_we,
  input  logic [DW-1:0] a_din,
  output logic [DW-1:0] a_dout,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_dout
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] a_dout_q, a_dout_d;
  logic [DW-1:0] b_dout_q, b_dout_d;

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_din;
  end

  always_comb begin
    a_dout_d = mem[a_addr];
    b_dout_d = mem[b_addr];
  end

  // Contents are not reset, only the output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_dout_q <= '0;
      b_dout_q <= '0;
    end else begin
      a_dout_q <= a_dout_d;
      b_dout_q <= b_dout_d;
    end
  end

  assign a_dout = a_dout_q;
  assign b_dout = b_dout_q;

endmodule

// File: rtl/jtcontra_obj_dma.sv
// rtl/jtcontra_obj_dma.sv - live object RAM plus shadow scan buffer refreshed at VBLANK start
module jtcontra_obj_dma
  import jtcontra_obj_dma_pkg::*;
#(
  parameter int AW       = 10,
  parameter int COPY_LEN = COPY_LEN_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          LVBL,
  input  logic          dma_en,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_dout,
  input  logic          cpu_we,
  output logic [7:0]    cpu_din,
  input  logic [AW-1:0] scan_addr,
  output logic [7:0]    obj_scan,
  output logic          busy
);

  localparam logic [AW:0] LAST = (AW+1)'(COPY_LEN - 1);

  dma_state_e    state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          last_lvbl_q, last_lvbl_d;
  logic          busy_q, busy_d;
  logic          start;
  logic          shd_we;
  logic [AW-1:0] shd_addr;
  logic [7:0]    live_rd;
  logic [7:0]    shadow_a_unused;

  assign start = last_lvbl_q && !LVBL && dma_en && (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    last_lvbl_d = LVBL;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COPY;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      COPY: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FLUSH;
      end
      FLUSH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_lvbl_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_lvbl_q <= last_lvbl_d;
      busy_q      <= busy_d;
    end
  end

  // The live read for cnt lands one cycle later, so the shadow write trails by one address.
  always_comb begin
    shd_we   = ((state_q == COPY) && (cnt_q != '0)) || (state_q == FLUSH);
    shd_addr = cnt_q[AW-1:0] - AW'(1);
  end

  jtframe_dual_ram #(.AW(AW), .DW(8)) u_live (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_addr (cpu_addr),
    .a_we   (cpu_we),
    .a_din  (cpu_dout),
    .a_dout (cpu_din),
    .b_addr (cnt_q[AW-1:0]),
    .b_dout (live_rd)
  );

  jtframe_dual_ram #(.AW(AW), .DW(8)) u_shadow (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_addr (shd_addr),
    .a_we   (shd_we),
    .a_din  (live_rd),
    .a_dout (shadow_a_unused),
    .b_addr (scan_addr),
    .b_dout (obj_scan)
  );

  assign busy = busy_q;

endmodule

// File: tb/tb_jtcontra_obj_dma.sv
// tb/tb_jtcontra_obj_dma.sv - directed self-checking bench for the object DMA
module tb_jtcontra_obj_dma;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          LVBL;
  logic          dma_en;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_dout;
  logic          cpu_we;
  logic [7:0]    cpu_din;
  logic [AW-1:0] scan_addr;
  logic [7:0]    obj_scan;
  logic          busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  jtcontra_obj_dma #(.AW(AW), .COPY_LEN(320)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .LVBL      (LVBL),
    .dma_en    (dma_en),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .cpu_we    (cpu_we),
    .cpu_din   (cpu_din),
    .scan_addr (scan_addr),
    .obj_scan  (obj_scan),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [7:0] d);
    cpu_addr = a;
    cpu_dout = d;
    cpu_we   = 1'b1;
    step();
    cpu_we   = 1'b0;
  endtask

  task automatic scan_rd(input logic [AW-1:0] a, output logic [7:0] d);
    scan_addr = a;
    step();
    d = obj_scan;
  endtask

  // Falls LVBL with the given enable and counts busy cycles after the start edge.
  task automatic run_copy(input logic en, output int n);
    LVBL   = 1'b0;
    dma_en = en;
    step();
    n = 0;
    while (busy && n < 1000) begin
      n++;
      step();
    end
    LVBL   = 1'b1;
    dma_en = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0; LVBL = 1'b1; dma_en = 1'b1;
    cpu_addr = '0; cpu_dout = '0; cpu_we = 1'b0; scan_addr = '0;
    step(); step(); step();
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (obj_scan !== 8'h00) $display("FAIL reset_obj_scan: got %h want 00", obj_scan); else n_pass++;
    n_total++; if (cpu_din !== 8'h00) $display("FAIL reset_cpu_din: got %h want 00", cpu_din); else n_pass++;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy !== 1'b0) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL idle_no_start: busy high %0d cycles want 0", bad); else n_pass++;
  endtask

  task automatic test_basic_copy();
    int n;
    logic [7:0] d;
    for (int i = 0; i < 320; i++) cpu_write(AW'(i), 8'(i) ^ 8'h5A);
    run_copy(1'b1, n);
    n_total++; if (n != 321) $display("FAIL basic_busy_len: got %0d want 321", n); else n_pass++;
    scan_rd(10'd0, d);
    n_total++; if (d !== 8'h5A) $display("FAIL basic_scan0: got %h want 5a", d); else n_pass++;
    scan_rd(10'd4, d);
    n_total++; if (d !== 8'h5E) $display("FAIL basic_scan4: got %h want 5e", d); else n_pass++;
    scan_rd(10'd319, d);
    n_total++; if (d !== 8'h65) $display("FAIL basic_scan319: got %h want 65", d); else n_pass++;
    scan_rd(10'd160, d);
    n_total++; if (d !== 8'hFA) $display("FAIL basic_scan160: got %h want fa", d); else n_pass++;
  endtask

  task automatic test_disabled();
    int n;
    logic [7:0] d;
    cpu_write(10'd2, 8'hF0);
    run_copy(1'b0, n);
    n_total++; if (n != 0) $display("FAIL dis_busy: got %0d busy cycles want 0", n); else n_pass++;
    scan_rd(10'd2, d);
    n_total++; if (d !== 8'h58) $display("FAIL dis_scan2: got %h want 58", d); else n_pass++;
  endtask

  task automatic test_mid_copy_write();
    int n;
    logic [7:0] d;
    LVBL = 1'b0; dma_en = 1'b1;
    step();
    n_total++; if (busy !== 1'b1) $display("FAIL mid_busy_start: got %b want 1", busy); else n_pass++;
    for (int i = 0; i < 100; i++) step();
    cpu_write(10'd200, 8'hAA);
    cpu_write(10'd50, 8'hBB);
    n = 0;
    while (busy && n < 1000) begin n++; step(); end
    LVBL = 1'b1; dma_en = 1'b0;
    step(); step();
    n_total++; if (n != 219) $display("FAIL mid_busy_rest: got %0d want 219", n); else n_pass++;
    scan_rd(10'd200, d);
    n_total++; if (d !== 8'hAA) $display("FAIL mid_scan200: got %h want aa", d); else n_pass++;
    scan_rd(10'd50, d);
    n_total++; if (d !== 8'h68) $display("FAIL mid_scan50_old: got %h want 68", d); else n_pass++;
    scan_rd(10'd2, d);
    n_total++; if (d !== 8'hF0) $display("FAIL mid_scan2: got %h want f0", d); else n_pass++;
    run_copy(1'b1, n);
    scan_rd(10'd50, d);
    n_total++; if (d !== 8'hBB) $display("FAIL mid_scan50_next: got %h want bb", d); else n_pass++;
  endtask

  task automatic test_reset_mid_copy();
    int n;
    logic [7:0] d;
    for (int i = 0; i < 320; i++) cpu_write(AW'(i), 8'(i) ^ 8'hC3);
    LVBL = 1'b0; dma_en = 1'b1;
    step();
    for (int i = 0; i < 150; i++) step();
    n_total++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy_async: got %b want 0", busy); else n_pass++;
    LVBL = 1'b1; dma_en = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step(); step();
    run_copy(1'b1, n);
    n_total++; if (n != 321) $display("FAIL rstmid_busy_len: got %0d want 321", n); else n_pass++;
    scan_rd(10'd0, d);
    n_total++; if (d !== 8'hC3) $display("FAIL rstmid_scan0: got %h want c3", d); else n_pass++;
    scan_rd(10'd200, d);
    n_total++; if (d !== 8'h0B) $display("FAIL rstmid_scan200: got %h want 0b", d); else n_pass++;
    scan_rd(10'd319, d);
    n_total++; if (d !== 8'hFC) $display("FAIL rstmid_scan319: got %h want fc", d); else n_pass++;
  endtask

  task automatic test_out_of_range();
    logic [AW-1:0] addrs [5];
    logic [7:0]    snap  [5];
    logic [7:0]    d;
    int n;
    addrs[0] = 10'd320; addrs[1] = 10'd321; addrs[2] = 10'd400;
    addrs[3] = 10'd700; addrs[4] = 10'd1023;
    for (int k = 0; k < 5; k++) scan_rd(addrs[k], snap[k]);
    for (int k = 0; k < 5; k++) cpu_write(addrs[k], 8'hE0 + 8'(k));
    run_copy(1'b1, n);
    for (int k = 0; k < 5; k++) begin
      scan_rd(addrs[k], d);
      n_total++;
      if (d !== snap[k]) $display("FAIL oor_scan%0d: got %h want %h", addrs[k], d, snap[k]);
      else n_pass++;
    end
    cpu_addr = 10'd400;
    step();
    n_total++; if (cpu_din !== 8'hE2) $display("FAIL oor_cpu_din400: got %h want e2", cpu_din); else n_pass++;
    cpu_addr = 10'd4;
    step();
    n_total++; if (cpu_din !== 8'hC7) $display("FAIL oor_cpu_din4: got %h want c7", cpu_din); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_disabled();
    test_mid_copy_write();
    test_reset_mid_copy();
    test_out_of_range();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
